// File: rtl/rx_frame_ctl.sv
// -----------------------------------------------------------------------------
// rx_frame_ctl
//
// Receive-side frame controller sitting behind the HDLC receive deframer.
// Each received frame is sequenced into one of two 256-byte slots of an
// external receive buffer RAM. Frames are filtered on the destination station
// (first byte). On the closing status a frame is committed or discarded.
// Committed frames are presented to the host oldest first. Saturating
// good/CRC/drop/abort counters are kept alongside.
//
// Ports
//   netclk          clock shared with the deframer and the buffer RAM
//   reset           asynchronous, active-high
//   byte_ready      deframer byte strobe (level; rising edge = new byte)
//   dout[7:0]       deframer byte, valid on the byte_ready rising edge
//   frame_complete  closing flag seen (level; rising edge counts)
//   frame_valid     FCS good, sampled on the frame_complete rising edge
//   frame_abort     abort sequence seen (level; rising edge counts)
//   idle            line idle (level)
//   my_station[7:0] local station number
//   promisc         accept every destination
//   buf_we          buffer write strobe
//   buf_addr[8:0]   buffer write address {slot, offset}
//   buf_wdata[7:0]  buffer write data
//   frame_avail     at least one committed slot
//   frame_slot      oldest committed slot
//   frame_len[8:0]  payload length of that slot, FCS excluded
//   frame_release   one-cycle pulse, frees the slot shown on frame_slot
//   cnt_good/crc/drop/abort[7:0]  saturating event counters
//   cnt_clear       synchronous clear of all four counters
// -----------------------------------------------------------------------------
module rx_frame_ctl #(
    parameter int         MIN_LEN     = 6,
    parameter int         GAP_TIMEOUT = 64,
    parameter logic [7:0] BCAST       = 8'hFF
) (
    input  logic       netclk,
    input  logic       reset,
    input  logic       byte_ready,
    input  logic [7:0] dout,
    input  logic       frame_complete,
    input  logic       frame_valid,
    input  logic       frame_abort,
    input  logic       idle,
    input  logic [7:0] my_station,
    input  logic       promisc,
    output logic       buf_we,
    output logic [8:0] buf_addr,
    output logic [7:0] buf_wdata,
    output logic       frame_avail,
    output logic       frame_slot,
    output logic [8:0] frame_len,
    input  logic       frame_release,
    output logic [7:0] cnt_good,
    output logic [7:0] cnt_crc,
    output logic [7:0] cnt_drop,
    output logic [7:0] cnt_abort,
    input  logic       cnt_clear
);

    localparam int         GW       = $clog2(GAP_TIMEOUT + 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_TIMEOUT);
    localparam logic [8:0] MIN_CNT  = 9'(MIN_LEN);
    localparam logic [8:0] MAX_CNT  = 9'd256;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          byte_ready_q, frame_complete_q, frame_abort_q;
    logic [8:0]    count_q, count_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          wr_slot_q, wr_slot_d;
    logic          rd_slot_q, rd_slot_d;
    logic [1:0]    full_q, full_d;
    logic [8:0]    len0_q, len0_d, len1_q, len1_d;
    logic          we_q, we_d;
    logic [8:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    good_q, good_d, crc_q, crc_d, drop_q, drop_d, abrt_q, abrt_d;

    logic byte_edge, complete_edge, abort_edge;
    logic gap_hit, abort_ev, dest_ok, release_ok, commit;
    logic inc_good, inc_crc, inc_drop, inc_abort;

    // Edge detection: pulse in the first cycle the level input is high.
    assign byte_edge     = byte_ready     & ~byte_ready_q;
    assign complete_edge = frame_complete & ~frame_complete_q;
    assign abort_edge    = frame_abort    & ~frame_abort_q;

    assign gap_hit    = (gap_q == GAP_MAX);
    assign abort_ev   = abort_edge | idle | gap_hit;
    assign dest_ok    = (dout == my_station) || (dout == BCAST) || promisc;
    assign release_ok = frame_release & (|full_q);

    // -------------------------------------------------------------------------
    // Frame sequencing FSM: next state, buffer write request, counter events.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; a missing default infers a latch.
        state_d   = state_q;
        count_d   = count_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        commit    = 1'b0;
        inc_good  = 1'b0;
        inc_crc   = 1'b0;
        inc_drop  = 1'b0;
        inc_abort = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (byte_edge) begin
                    if (full_q[wr_slot_q]) begin
                        // Both slots still held by the host: frame is lost.
                        inc_drop = 1'b1;
                        state_d  = ST_DISCARD;
                    end else if (dest_ok) begin
                        we_d    = 1'b1;
                        addr_d  = {wr_slot_q, 8'h00};
                        wdata_d = dout;
                        count_d = 9'd1;
                        state_d = ST_RECV;
                    end else begin
                        // Not addressed to us: skip silently.
                        state_d = ST_DISCARD;
                    end
                end
            end

            ST_RECV: begin
                // Abort outranks the closing flag, which outranks a new byte.
                if (abort_ev) begin
                    inc_abort = 1'b1;
                    state_d   = ST_IDLE;
                end else if (complete_edge) begin
                    if (!frame_valid) begin
                        inc_crc = 1'b1;
                    end else if (count_q >= MIN_CNT) begin
                        commit   = 1'b1;
                        inc_good = 1'b1;
                    end else begin
                        inc_drop = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else if (byte_edge) begin
                    if (count_q == MAX_CNT) begin
                        // Slot already holds 256 bytes: oversize frame.
                        inc_drop = 1'b1;
                        state_d  = ST_DISCARD;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = {wr_slot_q, count_q[7:0]};
                        wdata_d = dout;
                        count_d = count_q + 9'd1;
                    end
                end
            end

            ST_DISCARD: begin
                if (abort_ev || complete_edge) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Gap timer runs only inside a frame; any byte or fresh entry restarts it.
    always_comb begin
        gap_d = gap_q;
        if (state_q == ST_IDLE || state_d != state_q || byte_edge) begin
            gap_d = '0;
        end else if (!gap_hit) begin
            gap_d = gap_q + GW'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Slot bookkeeping. Commit and release touch different slots, so both may
    // apply in the same cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        full_d    = full_q;
        len0_d    = len0_q;
        len1_d    = len1_q;
        wr_slot_d = wr_slot_q;
        rd_slot_d = rd_slot_q;
        if (commit) begin
            full_d[wr_slot_q] = 1'b1;
            if (wr_slot_q) len1_d = count_q - 9'd2;
            else           len0_d = count_q - 9'd2;
            wr_slot_d = ~wr_slot_q;
        end
        if (release_ok) begin
            full_d[rd_slot_q] = 1'b0;
            rd_slot_d         = ~rd_slot_q;
        end
    end

    // -------------------------------------------------------------------------
    // Saturating counters; clear wins over a same-cycle increment.
    // -------------------------------------------------------------------------
    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc);
        return (inc && v != 8'hFF) ? v + 8'd1 : v;
    endfunction

    always_comb begin
        good_d = cnt_clear ? 8'h00 : sat_inc(good_q, inc_good);
        crc_d  = cnt_clear ? 8'h00 : sat_inc(crc_q,  inc_crc);
        drop_d = cnt_clear ? 8'h00 : sat_inc(drop_q, inc_drop);
        abrt_d = cnt_clear ? 8'h00 : sat_inc(abrt_q, inc_abort);
    end

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of evaluation order.
    always_ff @(posedge netclk or posedge reset) begin
        if (reset) begin
            // Edge detectors start high: a level already present when reset
            // is released is not treated as a new edge.
            byte_ready_q     <= 1'b1;
            frame_complete_q <= 1'b1;
            frame_abort_q    <= 1'b1;
            state_q          <= ST_IDLE;
            count_q          <= '0;
            gap_q            <= '0;
            wr_slot_q        <= 1'b0;
            rd_slot_q        <= 1'b0;
            full_q           <= '0;
            len0_q           <= '0;
            len1_q           <= '0;
            we_q             <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            good_q           <= '0;
            crc_q            <= '0;
            drop_q           <= '0;
            abrt_q           <= '0;
        end else begin
            byte_ready_q     <= byte_ready;
            frame_complete_q <= frame_complete;
            frame_abort_q    <= frame_abort;
            state_q          <= state_d;
            count_q          <= count_d;
            gap_q            <= gap_d;
            wr_slot_q        <= wr_slot_d;
            rd_slot_q        <= rd_slot_d;
            full_q           <= full_d;
            len0_q           <= len0_d;
            len1_q           <= len1_d;
            we_q             <= we_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            good_q           <= good_d;
            crc_q            <= crc_d;
            drop_q           <= drop_d;
            abrt_q           <= abrt_d;
        end
    end

    assign buf_we      = we_q;
    assign buf_addr    = addr_q;
    assign buf_wdata   = wdata_q;
    assign frame_avail = |full_q;
    assign frame_slot  = rd_slot_q;
    assign frame_len   = rd_slot_q ? len1_q : len0_q;
    assign cnt_good    = good_q;
    assign cnt_crc     = crc_q;
    assign cnt_drop    = drop_q;
    assign cnt_abort   = abrt_q;

endmodule
